// File: rtl/nd10_uc_pkg.sv
// nd10_uc_pkg: shared widths, fetch states and next-address select for the ND-10 micro-fetch path
package nd10_uc_pkg;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TMO = 15;
  localparam int STACK_DEPTH = 4;
  localparam int CW = $clog2(TMO + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} fetch_state_e;
  typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_CALL, SEL_RET} nxt_sel_e;
endpackage

// File: rtl/uc_stack.sv
// uc_stack: STACK_DEPTH x AW LIFO of micro-subroutine return addresses
module uc_stack import nd10_uc_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int IW = $clog2(STACK_DEPTH);
  logic [AW-1:0] mem_q [STACK_DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic [IW-1:0] top;
  assign full = sp_q == SW'(STACK_DEPTH);
  assign empty = sp_q == '0;
  assign top = IW'(sp_q - SW'(1));
  assign dout = mem_q[top];
  always_comb sp_d = (push && !full) ? sp_q + SW'(1) : (pop && !empty) ? sp_q - SW'(1) : sp_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sp_q <= '0;
    else sp_q <= sp_d;
  always_ff @(posedge clk)
    if (push && !full) mem_q[IW'(sp_q)] <= din;
endmodule

// File: rtl/uc_fetch.sv
// uc_fetch: ND-10 control-store fetch FSM (ROMRQ/ROMDRY initiator, UIR valid/ack handoff)
// Optional micro-subroutine return stack enabled by defining UC_STACK_EN.
module uc_fetch import nd10_uc_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic          halt,
  output logic          ROMRQ,
  output logic [AW-1:0] MPC,
  input  logic [DW-1:0] ROM,
  input  logic          ROMDRY,
  output logic [DW-1:0] UIR,
  output logic          uir_valid,
  input  logic          uir_ack,
  input  logic          br_take,
  input  logic [AW-1:0] br_addr,
  input  logic          call,
  input  logic          ret,
  output logic          tmo_err,
  output logic          stack_err
);
  fetch_state_e state_q, state_d;
  logic [AW-1:0] mpc_q, mpc_d, nxt;
  logic [DW-1:0] uir_q, uir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo_q, tmo_d, serr_q, serr_d;
  nxt_sel_e sel;
  assign nxt = mpc_q + AW'(1);
`ifdef UC_STACK_EN
  logic push, pop, stk_full, stk_empty;
  logic [AW-1:0] stk_dout;
  uc_stack u_stack (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(nxt),
    .dout(stk_dout), .full(stk_full), .empty(stk_empty)
  );
  assign sel = ret ? SEL_RET : call ? SEL_CALL : br_take ? SEL_BR : SEL_SEQ;
`else
  assign sel = (call || br_take) ? SEL_BR : SEL_SEQ;
`endif
  always_comb begin
    state_d = state_q;
    mpc_d = mpc_q;
    uir_d = uir_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    serr_d = serr_q;
`ifdef UC_STACK_EN
    push = 1'b0;
    pop = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        mpc_d = start_addr;
        tmo_d = 1'b0;
        serr_d = 1'b0;
        state_d = REQ;
      end
      REQ: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (ROMDRY) begin
        uir_d = ROM;
        state_d = FULL;
      end else if (cnt_q == CW'(TMO - 1)) begin
        tmo_d = 1'b1;
        state_d = IDLE;
      end else cnt_d = cnt_q + CW'(1);
      FULL: if (uir_ack) begin
        state_d = halt ? IDLE : REQ;
        if (!halt) begin
          mpc_d = sel == SEL_SEQ ? nxt : br_addr;
`ifdef UC_STACK_EN
          if (sel == SEL_CALL) begin
            push = !stk_full;
            serr_d = serr_q | stk_full;
          end
          if (sel == SEL_RET) begin
            pop = !stk_empty;
            mpc_d = stk_empty ? '0 : stk_dout;
            serr_d = serr_q | stk_empty;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mpc_q <= '0;
      uir_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mpc_q <= mpc_d;
      uir_q <= uir_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      serr_q <= serr_d;
    end
  assign ROMRQ = state_q == REQ;
  assign uir_valid = state_q == FULL;
  assign MPC = mpc_q;
  assign UIR = uir_q;
  assign tmo_err = tmo_q;
  assign stack_err = serr_q;
endmodule

// File: tb/tb_uc_fetch.sv
// tb_uc_fetch: directed bench for uc_fetch with a one-clock PROM responder model
module tb_uc_fetch;
  logic clk = 0, rst_n = 0, start = 0, halt = 0, uir_ack = 0, br_take = 0, call = 0, ret = 0;
  logic [11:0] start_addr = 0, br_addr = 0;
  logic ROMRQ, uir_valid, tmo_err, stack_err, ROMDRY;
  logic [11:0] MPC;
  logic [31:0] UIR, rom_q = 0;
  logic dry_q = 0, prom_en = 1, late_dry = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign ROMDRY = dry_q | late_dry;
  uc_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .halt(halt),
    .ROMRQ(ROMRQ), .MPC(MPC), .ROM(rom_q), .ROMDRY(ROMDRY), .UIR(UIR), .uir_valid(uir_valid),
    .uir_ack(uir_ack), .br_take(br_take), .br_addr(br_addr), .call(call), .ret(ret),
    .tmo_err(tmo_err), .stack_err(stack_err)
  );
  function automatic logic [31:0] mem(input logic [11:0] a);
    return {4'hC, a, 4'h3, ~a};
  endfunction
  always @(posedge clk) begin
    dry_q <= ROMRQ & prom_en;
    rom_q <= mem(MPC);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rq;
    for (int i = 0; i < 20 && !ROMRQ; i++) tick();
    chk("rq_seen", {31'd0, ROMRQ}, 32'd1);
  endtask
  task automatic fetch(input logic [11:0] a);
    wait_rq();
    chk("rq_mpc", {20'd0, MPC}, {20'd0, a});
    tick();
    tick();
    chk("uir_valid", {31'd0, uir_valid}, 32'd1);
    chk("uir", UIR, mem(a));
  endtask
  task automatic ack(input logic h, input logic b, input logic c, input logic r, input logic [11:0] t);
    {halt, br_take, call, ret, br_addr, uir_ack} = {h, b, c, r, t, 1'b1};
    tick();
    {halt, br_take, call, ret, br_addr, uir_ack} = '0;
  endtask
  task automatic go(input logic [11:0] a);
    start = 1;
    start_addr = a;
    tick();
    start = 0;
  endtask
  initial begin
    int n;
    logic [31:0] held;
    tick();
    tick();
    chk("rst_romrq", {31'd0, ROMRQ}, 0);
    chk("rst_mpc", {20'd0, MPC}, 0);
    chk("rst_uir", UIR, 0);
    chk("rst_valid", {31'd0, uir_valid}, 0);
    chk("rst_errs", {30'd0, tmo_err, stack_err}, 0);
    rst_n = 1;
    tick();
    go(12'h010);
    fetch(12'h010);
    ack(0, 0, 0, 0, 0);
    fetch(12'h011);
    ack(0, 0, 0, 0, 0);
    fetch(12'h012);
    ack(1, 1, 0, 0, 12'h555);
    tick();
    tick();
    chk("halt_idle_rq", {31'd0, ROMRQ}, 0);
    chk("halt_mpc", {20'd0, MPC}, 32'h012);
    go(12'hFFF);
    fetch(12'hFFF);
    ack(0, 0, 0, 0, 0);
    fetch(12'h000);
    chk("wrap_tmo", {31'd0, tmo_err}, 0);
    ack(1, 0, 0, 0, 0);
    go(12'h020);
    fetch(12'h020);
    ack(0, 1, 0, 0, 12'h200);
    fetch(12'h200);
    held = UIR;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n += int'(ROMRQ);
    end
    chk("hold_rq", n, 0);
    chk("hold_uir", UIR, held);
    chk("hold_valid", {31'd0, uir_valid}, 1);
    ack(1, 0, 0, 0, 0);
    prom_en = 0;
    go(12'h050);
    wait_rq();
    n = 0;
    for (int i = 0; i < 30 && !tmo_err; i++) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_err", {31'd0, tmo_err}, 1);
    tick();
    chk("tmo_idle", {30'd0, ROMRQ, uir_valid}, 0);
    prom_en = 1;
    go(12'h060);
    chk("tmo_clear", {31'd0, tmo_err}, 0);
    fetch(12'h060);
    ack(1, 0, 0, 0, 0);
    go(12'h040);
    fetch(12'h040);
    ack(0, 0, 1, 0, 12'h300);
    fetch(12'h300);
    ack(0, 0, 0, 1, 0);
`ifdef UC_STACK_EN
    fetch(12'h041);
    for (int i = 0; i < 5; i++) begin
      ack(0, 0, 1, 0, 12'h100 + 12'(i));
      fetch(12'h100 + 12'(i));
    end
    chk("stk_over", {31'd0, stack_err}, 1);
    ack(0, 0, 0, 1, 0);
    fetch(12'h103);
    ack(0, 0, 0, 1, 0);
    fetch(12'h102);
    ack(0, 0, 0, 1, 0);
    fetch(12'h101);
    ack(0, 0, 0, 1, 0);
    fetch(12'h042);
    ack(0, 1, 1, 1, 12'h777);
    fetch(12'h000);
    chk("stk_under", {31'd0, stack_err}, 1);
`else
    fetch(12'h301);
    chk("nostk_err", {31'd0, stack_err}, 0);
`endif
    ack(1, 0, 0, 0, 0);
    prom_en = 0;
    go(12'h070);
    wait_rq();
    tick();
    rst_n = 0;
    #1;
    chk("wrst_romrq", {31'd0, ROMRQ}, 0);
    chk("wrst_mpc", {20'd0, MPC}, 0);
    chk("wrst_uir", UIR, 0);
    chk("wrst_flags", {29'd0, uir_valid, tmo_err, stack_err}, 0);
    tick();
    rst_n = 1;
    late_dry = 1;
    tick();
    late_dry = 0;
    tick();
    chk("late_dry_valid", {31'd0, uir_valid}, 0);
    chk("late_dry_uir", UIR, 0);
    chk("late_dry_rq", {31'd0, ROMRQ}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
